// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity mode codes,
// receiver state encoding and a configuration legality check.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // True when the receiver parameters fall inside the supported range.
    function automatic bit uart_cfg_legal(input int clks_per_bit,
                                          input int data_bits,
                                          input int parity_mode,
                                          input int stop_bits);
        return (clks_per_bit >= 4) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: a two-flop synchroniser for the
// asynchronous serial line followed by a three-sample history whose majority
// gives a glitch-tolerant bit value.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic bit_val
);

    logic       rxd_meta;
    logic [2:0] hist;

    // Synchronise the line and keep the last three synchronised samples; idle-high on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            hist     <= 3'b111;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
            hist     <= {hist[1:0], rxd_s};
        end
    end

    // Two-out-of-three vote over the sample history.
    assign bit_val = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits and bit period are
// parameters. Detects framing errors, parity errors and line breaks, and after
// any framing error waits for a full bit time of idle line before re-arming.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_valid,
    output logic                 uart_err,
    output logic                 uart_parity_err,
    output logic                 uart_break
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_DECIDE = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam bit            CFG_OK     = uart_cfg_legal(CLKS_PER_BIT, DATA_BITS,
                                                          PARITY_MODE, STOP_BITS);

    if (!CFG_OK) begin : g_bad_cfg
        $error("uart_rx_cfg: unsupported parameter combination");
    end

    rx_state_t            state, state_next;
    logic [CW-1:0]        cnt, cnt_next, cnt_step;
    logic [IW-1:0]        bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_bit, par_next;
    logic                 stop_idx, stop_idx_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next, err_next, perr_next, brk_next;
    logic                 rxd_s, bit_val;
    logic                 decide, data_xor, parity_ok, break_pattern;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .rxd_s    (rxd_s),
        .bit_val  (bit_val)
    );

    assign decide   = (cnt == CNT_DECIDE);
    assign cnt_step = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    assign data_xor = ^shift_reg;

    // Parity is judged against the received data once the parity bit has been latched.
    assign parity_ok = (PARITY_MODE == PARITY_EVEN) ? ~(data_xor ^ par_bit) :
                       (PARITY_MODE == PARITY_ODD)  ?  (data_xor ^ par_bit) : 1'b1;

    // A break is an all-zero frame whose very first stop bit is also zero.
    assign break_pattern = (shift_reg == '0) &&
                           ((PARITY_MODE == PARITY_NONE) || !par_bit) &&
                           (stop_idx == 1'b0);

    // Next-state, counters and output pulses; every frame ends in exactly one outcome.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        par_next      = par_bit;
        stop_idx_next = stop_idx;
        data_next     = uart_rx_data;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        perr_next     = 1'b0;
        brk_next      = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rxd_s) begin
                    state_next = START;
                end
            end

            START: begin
                cnt_next = cnt_step;
                if (decide) begin
                    if (bit_val) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end

            DATA: begin
                cnt_next = cnt_step;
                if (decide) begin
                    shift_next   = {bit_val, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_next    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        stop_idx_next = 1'b0;
                    end
                end
            end

            PARITY: begin
                cnt_next = cnt_step;
                if (decide) begin
                    par_next      = bit_val;
                    state_next    = STOP;
                    stop_idx_next = 1'b0;
                end
            end

            STOP: begin
                cnt_next = cnt_step;
                if (decide) begin
                    if (!bit_val) begin
                        err_next   = 1'b1;
                        brk_next   = break_pattern;
                        perr_next  = !break_pattern && !parity_ok;
                        state_next = WAIT_IDLE;
                        cnt_next   = '0;
                    end else if (stop_idx == STOP_LAST) begin
                        if (parity_ok) begin
                            valid_next = 1'b1;
                            data_next  = shift_reg;
                        end else begin
                            perr_next  = 1'b1;
                        end
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end

            WAIT_IDLE: begin
                if (!rxd_s) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, datapath and registered output pulses; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            par_bit         <= 1'b0;
            stop_idx        <= 1'b0;
            uart_rx_data    <= '0;
            uart_valid      <= 1'b0;
            uart_err        <= 1'b0;
            uart_parity_err <= 1'b0;
            uart_break      <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            bit_idx         <= bit_idx_next;
            shift_reg       <= shift_next;
            par_bit         <= par_next;
            stop_idx        <= stop_idx_next;
            uart_rx_data    <= data_next;
            uart_valid      <= valid_next;
            uart_err        <= err_next;
            uart_parity_err <= perr_next;
            uart_break      <= brk_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard testbench for uart_rx_cfg. Three receivers with different
// configurations share clock and reset; each has its own serial line and
// expected-event queue, and a monitor compares every flag/valid pulse.
module tb_uart_rx_cfg;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic       perr;
        logic       brk;
        logic [8:0] data;
    } ev_t;

    logic clk;
    logic reset;
    logic rxd0, rxd1, rxd2;

    logic [7:0] data0;
    logic [6:0] data1;
    logic [7:0] data2;
    logic       valid0, err0, perr0, brk0;
    logic       valid1, err1, perr1, brk1;
    logic       valid2, err2, perr2, brk2;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];

    int tests_run;
    int tests_failed;

    // 8N1, 16 clocks per bit
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_basic (
        .clk(clk), .reset(reset), .uart_rxd(rxd0), .uart_rx_data(data0),
        .uart_valid(valid0), .uart_err(err0), .uart_parity_err(perr0), .uart_break(brk0));

    // 7 data bits, even parity, one stop bit
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_par (
        .clk(clk), .reset(reset), .uart_rxd(rxd1), .uart_rx_data(data1),
        .uart_valid(valid1), .uart_err(err1), .uart_parity_err(perr1), .uart_break(brk1));

    // 8 data bits, no parity, two stop bits
    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .uart_rxd(rxd2), .uart_rx_data(data2),
        .uart_valid(valid2), .uart_err(err2), .uart_parity_err(perr2), .uart_break(brk2));

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rxd0 = v;
            1:       rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic idle(input int sel, input int n);
        drive(sel, 1'b1);
        repeat (n) @(negedge clk);
    endtask

    // One bit period; optionally inverts the line for a single cycle at mid-bit.
    task automatic hold_bit(input int sel, input logic v, input bit spike);
        drive(sel, v);
        if (spike) begin
            repeat (8) @(negedge clk);
            drive(sel, !v);
            @(negedge clk);
            drive(sel, v);
            repeat (7) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    // Drives one frame: start, data LSB first, optional parity (par < 0 means none), stop bits.
    task automatic apply_stimulus(input int sel, input logic [8:0] data, input int nbits,
                                  input int par, input logic [1:0] stops, input int nstop,
                                  input int spike);
        hold_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(sel, data[i], (i == spike));
        if (par >= 0) hold_bit(sel, par[0], 1'b0);
        for (int i = 0; i < nstop; i++) hold_bit(sel, stops[i], 1'b0);
    endtask

    task automatic expect_event(input int sel, input logic v, input logic e, input logic p,
                                input logic b, input logic [8:0] d);
        ev_t ev;
        ev = '{valid: v, err: e, perr: p, brk: b, data: d};
        case (sel)
            0:       q0.push_back(ev);
            1:       q1.push_back(ev);
            default: q2.push_back(ev);
        endcase
    endtask

    task automatic check_value(input string name, input int actual, input int required);
        tests_run++;
        if (actual != required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // Pops the oldest expected event for a receiver and compares it with what was observed.
    task automatic check_output(input int sel, input ev_t obs);
        ev_t exp;
        bit  have;
        have = 1'b0;
        exp  = '0;
        case (sel)
            0:       if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
        endcase
        tests_run++;
        if (!have) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_event rx%0d: got v=%b e=%b p=%b b=%b data=%h, required no event",
                     sel, obs.valid, obs.err, obs.perr, obs.brk, obs.data);
        end else if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL event rx%0d: got v=%b e=%b p=%b b=%b data=%h, required v=%b e=%b p=%b b=%b data=%h",
                     sel, obs.valid, obs.err, obs.perr, obs.brk, obs.data,
                     exp.valid, exp.err, exp.perr, exp.brk, exp.data);
        end
    endtask

    // Monitor: any pulse on a receiver's outputs is one observed event.
    always @(negedge clk) begin
        if (reset) begin
            if (valid0 | err0 | perr0 | brk0)
                check_output(0, '{valid: valid0, err: err0, perr: perr0, brk: brk0, data: {1'b0, data0}});
            if (valid1 | err1 | perr1 | brk1)
                check_output(1, '{valid: valid1, err: err1, perr: perr1, brk: brk1, data: {2'b0, data1}});
            if (valid2 | err2 | perr2 | brk2)
                check_output(2, '{valid: valid2, err: err2, perr: perr2, brk: brk2, data: {1'b0, data2}});
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with expected events pushed before each frame.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        rxd0  = 1'b1;
        rxd1  = 1'b1;
        rxd2  = 1'b1;
        repeat (3) @(negedge clk);

        check_value("reset_rx0_data",  int'(data0), 0);
        check_value("reset_rx0_flags", int'({valid0, err0, perr0, brk0}), 0);
        check_value("reset_rx1_all",   int'({data1, valid1, err1, perr1, brk1}), 0);
        check_value("reset_rx2_all",   int'({data2, valid2, err2, perr2, brk2}), 0);

        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Basic frame followed back-to-back by a second frame
        expect_event(0, 1, 0, 0, 0, 9'h0A5);
        apply_stimulus(0, 9'h0A5, 8, -1, 2'b11, 1, -1);
        expect_event(0, 1, 0, 0, 0, 9'h0C3);
        apply_stimulus(0, 9'h0C3, 8, -1, 2'b11, 1, -1);
        idle(0, 30);

        // Short low glitch on an idle line must be ignored
        drive(0, 1'b0);
        repeat (3) @(negedge clk);
        idle(0, 40);

        // Single-cycle spike at mid-bit of data bit 3 is outvoted
        expect_event(0, 1, 0, 0, 0, 9'h000);
        apply_stimulus(0, 9'h000, 8, -1, 2'b11, 1, 3);
        idle(0, 20);
        expect_event(0, 1, 0, 0, 0, 9'h066);
        apply_stimulus(0, 9'h066, 8, -1, 2'b11, 1, -1);
        idle(0, 20);

        // Even parity: good parity, bad parity (data held), then odd-weight word
        expect_event(1, 1, 0, 0, 0, 9'h035);
        apply_stimulus(1, 9'h035, 7, 0, 2'b11, 1, -1);
        idle(1, 20);
        expect_event(1, 0, 0, 1, 0, 9'h035);
        apply_stimulus(1, 9'h035, 7, 1, 2'b11, 1, -1);
        idle(1, 20);
        expect_event(1, 1, 0, 0, 0, 9'h007);
        apply_stimulus(1, 9'h007, 7, 1, 2'b11, 1, -1);
        idle(1, 20);

        // Two stop bits: second stop low is a framing error, then re-arm after 16 idle cycles
        expect_event(2, 0, 1, 0, 0, 9'h000);
        apply_stimulus(2, 9'h03C, 8, -1, 2'b01, 2, -1);
        idle(2, 16);
        expect_event(2, 1, 0, 0, 0, 9'h081);
        apply_stimulus(2, 9'h081, 8, -1, 2'b11, 2, -1);
        idle(2, 20);

        // Break: line low for three frame times, one break+err pulse, data unchanged
        expect_event(0, 0, 1, 0, 1, 9'h066);
        drive(0, 1'b0);
        repeat (480) @(negedge clk);
        idle(0, 20);
        expect_event(0, 1, 0, 0, 0, 9'h05A);
        apply_stimulus(0, 9'h05A, 8, -1, 2'b11, 1, -1);
        idle(0, 20);

        // Reset in the middle of data bit 4 clears outputs without waiting for a clock edge
        hold_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(0, (i == 1), 1'b0);
        drive(0, 1'b1);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_value("async_reset_rx0_data",  int'(data0), 0);
        check_value("async_reset_rx0_flags", int'({valid0, err0, perr0, brk0}), 0);
        check_value("async_reset_rx1_data",  int'(data1), 0);
        check_value("async_reset_rx2_data",  int'(data2), 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(0, 20);
        expect_event(0, 1, 0, 0, 0, 9'h0FF);
        apply_stimulus(0, 9'h0FF, 8, -1, 2'b11, 1, -1);
        idle(0, 40);

        // Every expected event must have been observed
        check_value("pending_rx0", q0.size(), 0);
        check_value("pending_rx1", q1.size(), 0);
        check_value("pending_rx2", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
